// File: rtl/alu_instr_issuer_if.sv
// Pin bundle between the host-side instruction issuer and its program/core/result peers.
// slave is the issuer's view; master is the host/core side that drives programs and results.
interface alu_instr_issuer_if #(
   parameter int ADDR_W = 4
);
   logic              prog_we;
   logic [ADDR_W-1:0] prog_addr;
   logic [2:0]        prog_rd;
   logic [2:0]        prog_rs1;
   logic [2:0]        prog_rs2;
   logic [3:0]        prog_func;
   logic              prog_wb;
   logic [ADDR_W:0]   prog_len;
   logic              start;
   logic              busy;
   logic              done;
   logic              halted;
   logic [15:0]       instr_out;
   logic [7:0]        result_in;
   logic              zero_in;
   logic              res_valid;
   logic              res_ready;
   logic [7:0]        res_data;
   logic              res_zero;
   logic [ADDR_W-1:0] res_idx;

   modport master (
      output prog_we, prog_addr, prog_rd, prog_rs1, prog_rs2, prog_func, prog_wb,
      output prog_len, start, result_in, zero_in, res_ready,
      input  busy, done, halted, instr_out, res_valid, res_data, res_zero, res_idx
   );

   modport slave (
      input  prog_we, prog_addr, prog_rd, prog_rs1, prog_rs2, prog_func, prog_wb,
      input  prog_len, start, result_in, zero_in, res_ready,
      output busy, done, halted, instr_out, res_valid, res_data, res_zero, res_idx
   );
endinterface

// File: rtl/alu_instr_issuer.sv
// Issues a stored ALU program to the core as READ/EXEC pairs and streams each captured result.
// Latency: 2 cycles per instruction minimum; done pulses the cycle after the last EXEC.
// Backpressure: an unconsumed result holds the issuer in READ. ISSUER_ZERO_HALT_EN: stop on zero.
module alu_instr_issuer #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   alu_instr_issuer_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W:0]   len_q;
   logic              done_q;
   logic              res_valid_q;
   logic [7:0]        res_data_q;
   logic              res_zero_q;
   logic [ADDR_W-1:0] res_idx_q;

   logic [12:0]       slot_fld [DEPTH];
   logic [DEPTH-1:0]  slot_wb;

   logic [12:0]       cur_fld;
   logic              cur_wb;
   logic              last_instr;
   logic              zero_stop;
   logic              end_prog;
   logic              start_ok;
   logic              busy_c;
   logic [15:0]       instr_c;

   assign cur_fld    = slot_fld[pc_q];
   assign cur_wb     = slot_wb[pc_q];
   assign last_instr = ({1'b0, pc_q} == (len_q - (ADDR_W+1)'(1)));
   assign start_ok   = (state_q == S_IDLE) && bus.start;
   assign end_prog   = (state_q == S_EXEC) && (last_instr || zero_stop);

   // Program store is deliberately left out of reset; writes only land while idle.
   always_ff @(posedge clk) begin
      if (bus.prog_we && (state_q == S_IDLE)) begin
         slot_fld[bus.prog_addr] <= {bus.prog_rd, bus.prog_rs1, bus.prog_rs2, bus.prog_func};
         slot_wb[bus.prog_addr]  <= bus.prog_wb;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start && (bus.prog_len != '0)) begin
               state_d = S_READ;
            end
         end
         S_READ: begin
            // The result register must be free (or draining now) before the next capture.
            if (!(res_valid_q && !bus.res_ready)) begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = end_prog ? S_IDLE : S_READ;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy_c  = 1'b0;
      instr_c = 16'h0000;
      case (state_q)
         S_READ: begin
            busy_c  = 1'b1;
            instr_c = {cur_fld, 3'b000};
         end
         S_EXEC: begin
            busy_c  = 1'b1;
            instr_c = {cur_fld, (cur_wb ? 3'b011 : 3'b000)};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q        <= '0;
         len_q       <= '0;
         done_q      <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_zero_q  <= 1'b0;
         res_idx_q   <= '0;
      end else begin
         done_q <= (start_ok && (bus.prog_len == '0)) || end_prog;
         if (start_ok) begin
            pc_q  <= '0;
            len_q <= bus.prog_len;
         end else if ((state_q == S_EXEC) && !end_prog) begin
            pc_q <= pc_q + ADDR_W'(1);
         end
         if (state_q == S_EXEC) begin
            res_valid_q <= 1'b1;
            res_data_q  <= bus.result_in;
            res_zero_q  <= bus.zero_in;
            res_idx_q   <= pc_q;
         end else if (res_valid_q && bus.res_ready) begin
            res_valid_q <= 1'b0;
         end
      end
   end

`ifdef ISSUER_ZERO_HALT_EN
   logic halted_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         halted_q <= 1'b0;
      end else if (start_ok) begin
         halted_q <= 1'b0;
      end else if ((state_q == S_EXEC) && bus.zero_in) begin
         halted_q <= 1'b1;
      end
   end

   assign zero_stop  = bus.zero_in;
   assign bus.halted = halted_q;
`else
   assign zero_stop  = 1'b0;
   assign bus.halted = 1'b0;
`endif

   assign bus.busy      = busy_c;
   assign bus.done      = done_q;
   assign bus.instr_out = instr_c;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_zero  = res_zero_q;
   assign bus.res_idx   = res_idx_q;

endmodule

// File: tb/tb_alu_instr_issuer.sv
// Bench for alu_instr_issuer: directed phasing checks plus randomized programs against a slot-level model.
module tb_alu_instr_issuer;

`ifdef ISSUER_ZERO_HALT_EN
   localparam bit HALT = 1'b1;
`else
   localparam bit HALT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_instr_issuer_if #(.ADDR_W(4)) bus ();

   alu_instr_issuer #(.DEPTH(16), .ADDR_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   logic [2:0]  m_rd   [16];
   logic [2:0]  m_rs1  [16];
   logic [2:0]  m_rs2  [16];
   logic [3:0]  m_func [16];
   logic        m_wb   [16];
   logic [12:0] exp_q  [$];

   function automatic logic [15:0] enc(input int s, input bit ex);
      int v;
      v = int'(m_rd[s]) * 8192 + int'(m_rs1[s]) * 1024 + int'(m_rs2[s]) * 128
        + int'(m_func[s]) * 8 + ((ex && m_wb[s]) ? 3 : 0);
      return v[15:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      logic [12:0] e;
      if (!rst) begin
         chk("res_valid_hold", bus.res_valid, exp_q.size() != 0);
         if (bus.res_valid && bus.res_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("res_idx",  bus.res_idx,  e[12:9]);
            chk("res_data", bus.res_data, e[8:1]);
            chk("res_zero", bus.res_zero, e[0]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic write_slot(input int a, input int rd, input int rs1, input int rs2,
                             input int func, input int wb);
      bus.prog_we   = 1'b1;
      bus.prog_addr = 4'(a);
      bus.prog_rd   = 3'(rd);
      bus.prog_rs1  = 3'(rs1);
      bus.prog_rs2  = 3'(rs2);
      bus.prog_func = 4'(func);
      bus.prog_wb   = 1'(wb);
      tick();
      bus.prog_we   = 1'b0;
      m_rd[a] = 3'(rd); m_rs1[a] = 3'(rs1); m_rs2[a] = 3'(rs2);
      m_func[a] = 4'(func); m_wb[a] = 1'(wb);
   endtask

   task automatic junk_inputs(input bit en);
      if (en) begin
         bus.prog_we   = 1'($urandom);
         bus.prog_addr = 4'($urandom);
         bus.prog_rd   = 3'($urandom);
         bus.prog_rs1  = 3'($urandom);
         bus.prog_rs2  = 3'($urandom);
         bus.prog_func = 4'($urandom);
         bus.prog_wb   = 1'($urandom);
         bus.start     = 1'($urandom);
         bus.prog_len  = 5'($urandom);
      end
   endtask

   // Run one program: ready is held low for the first `hold` cycles, zero_in rises only at zero_idx.
   task automatic run_prog(input int len, input int hold, input int zero_idx, input bit junk);
      int  c;
      bit  stall, z, fin;
      logic [7:0] r;
      bus.prog_len = 5'(len);
      bus.start    = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("halted_clr", bus.halted, 1'b0);
      if (len == 0) begin
         chk("len0_done", bus.done, 1'b1);
         chk("len0_busy", bus.busy, 1'b0);
         chk("len0_instr", bus.instr_out, 16'h0000);
         tick();
         chk("len0_done_end", bus.done, 1'b0);
         return;
      end
      c = 0;
      fin = 1'b0;
      for (int i = 0; i < len && !fin; i++) begin
         stall = 1'b1;
         for (int k = 0; k < 100 && stall; k++) begin
            chk("read_instr", bus.instr_out, enc(i, 1'b0));
            chk("read_busy", bus.busy, 1'b1);
            chk("read_done", bus.done, 1'b0);
            bus.res_ready = (c >= hold) && ($urandom_range(0, 99) < 70);
            c++;
            bus.result_in = 8'($urandom);
            bus.zero_in   = 1'($urandom);
            junk_inputs(junk);
            stall = (exp_q.size() != 0) && !bus.res_ready;
            tick();
         end
         chk("stall_bound", stall, 1'b0);
         chk("exec_instr", bus.instr_out, enc(i, 1'b1));
         chk("exec_busy", bus.busy, 1'b1);
         r = 8'($urandom);
         z = (i == zero_idx);
         bus.result_in = r;
         bus.zero_in   = z;
         bus.res_ready = (c >= hold) && ($urandom_range(0, 99) < 70);
         c++;
         junk_inputs(junk);
         tick();
         exp_q.push_back({4'(i), r, z});
         fin = (i == len - 1) || (HALT && z);
      end
      bus.prog_we = 1'b0;
      bus.start   = 1'b0;
      chk("end_done", bus.done, 1'b1);
      chk("end_busy", bus.busy, 1'b0);
      chk("end_instr", bus.instr_out, 16'h0000);
      chk("end_halted", bus.halted, HALT && (zero_idx >= 0) && (zero_idx < len));
      bus.res_ready = 1'b1;
      for (int k = 0; k < 10 && exp_q.size() != 0; k++) tick();
      chk("drain", exp_q.size(), 0);
      tick();
      chk("post_done", bus.done, 1'b0);
      chk("post_valid", bus.res_valid, 1'b0);
      chk("halted_sticky", bus.halted, HALT && (zero_idx >= 0) && (zero_idx < len));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_rd = '0; bus.prog_rs1 = '0;
      bus.prog_rs2 = '0; bus.prog_func = '0; bus.prog_wb = 1'b0; bus.prog_len = '0;
      bus.start = 1'b0; bus.result_in = '0; bus.zero_in = 1'b0; bus.res_ready = 1'b0;

      tick();
      tick();
      chk("rst_instr", bus.instr_out, 16'h0000);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_valid", bus.res_valid, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_halted", bus.halted, 1'b0);
      chk("rst_data", bus.res_data, 8'h00);
      chk("rst_idx", bus.res_idx, 4'h0);
      rst = 1'b0;

      // Single instruction with hand-computed encodings
      write_slot(0, 2, 3, 1, 6, 1);
      bus.prog_len = 5'd1;
      bus.start    = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("d_read_instr", bus.instr_out, 16'h4CB0);
      chk("d_read_busy", bus.busy, 1'b1);
      tick();
      chk("d_exec_instr", bus.instr_out, 16'h4CB3);
      bus.result_in = 8'h04;
      bus.zero_in   = 1'b0;
      tick();
      exp_q.push_back({4'd0, 8'h04, 1'b0});
      chk("d_res_data", bus.res_data, 8'h04);
      chk("d_res_zero", bus.res_zero, 1'b0);
      chk("d_res_idx", bus.res_idx, 4'd0);
      chk("d_done", bus.done, 1'b1);
      chk("d_busy", bus.busy, 1'b0);
      bus.res_ready = 1'b1;
      tick();
      chk("d_done_low", bus.done, 1'b0);

      for (int a = 0; a < 16; a++)
         write_slot(a, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 15), $urandom_range(0, 1));

      run_prog(3, 6, -1, 1'b0);
      run_prog(0, 0, -1, 1'b0);
      run_prog(5, 0, -1, 1'b1);
      run_prog(5, 0, -1, 1'b0);
      run_prog(4, 2, 1, 1'b0);
      run_prog(4, 0, -1, 1'b0);
      run_prog(16, 0, -1, 1'b0);
      for (int n = 0; n < 6; n++) begin
         int len;
         len = $urandom_range(1, 16);
         run_prog(len, $urandom_range(0, 5),
                  ($urandom_range(0, 1) != 0) ? $urandom_range(0, len - 1) : -1,
                  1'($urandom));
      end

      // Reset during EXEC drops the pending capture
      bus.res_ready = 1'b0;
      bus.prog_len  = 5'd8;
      bus.start     = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      chk("abort_exec", bus.instr_out, enc(0, 1'b1));
      rst = 1'b1;
      tick();
      chk("abort_instr", bus.instr_out, 16'h0000);
      chk("abort_busy", bus.busy, 1'b0);
      chk("abort_valid", bus.res_valid, 1'b0);
      exp_q.delete();
      rst = 1'b0;
      tick();
      run_prog(2, 1, -1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
